// File: rtl/ras_pkg.sv
// ras_pkg: shared constants and types for the return-address-stack controller.
// Stack depth and checkpoint slot count are fixed here, so that the checkpoint
// record type and the controller always agree on pointer and counter widths.
package ras_pkg;

    localparam int RAS_DATAWIDTH  = 40;
    localparam int RAS_DEPTH_LOG2 = 3;
    localparam int RAS_CKPT_LOG2  = 2;
    localparam int RAS_NUM_CKPT   = 2 ** RAS_CKPT_LOG2;

    // The count is one bit wider than tos so that "full" can be represented.
    localparam logic [RAS_DEPTH_LOG2:0] RAS_COUNT_FULL = {1'b1, {RAS_DEPTH_LOG2{1'b0}}};

    typedef struct packed {
        logic [RAS_DEPTH_LOG2-1:0] tos;
        logic [RAS_DEPTH_LOG2:0]   count;
    } ras_ckpt_t;

    typedef enum logic {
        RAS_IDLE,
        RAS_RECOVER
    } ras_state_e;

endpackage

// File: rtl/ras_stack_mem.sv
// ras_stack_mem: PC storage array for the return-address stack.
// Ports:
//   clk      - clock
//   we_i     - write enable (synchronous write)
//   waddr_i  - write index
//   wdata_i  - PC to store
//   raddr_i  - read index (asynchronous read)
//   rdata_o  - PC stored at raddr_i
// The array is not reset; entries are undefined until written.
module ras_stack_mem #(
    parameter int DATAWIDTH  = 40,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATAWIDTH-1:0]  wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATAWIDTH-1:0]  rdata_o
);

    logic [DATAWIDTH-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ras_ctrl.sv
// ras_ctrl: speculative return-address-stack controller.
// Turns call/return hints into push/pop operations on ras_stack_mem, supplies
// the predicted return PC, and checkpoints {tos, count} per branch tag so a
// misprediction flush can roll the stack pointer back.
// Ports:
//   clk, rstn                     - clock, async active-low reset
//   i_call, i_call_pc             - push request and return address
//   i_ret                         - pop request
//   o_pred_pc, o_pred_valid       - predicted return PC (combinational) / valid
//   i_ckpt_en, i_ckpt_tag         - snapshot post-update {tos, count} into slot
//   i_flush, i_flush_tag          - restore from slot, enter RECOVER
//   i_ckpt_free, i_free_tag       - invalidate slot
//   o_busy, o_full, o_empty       - status
//
// state       | meaning
// ------------+-------------------------------------------------------------
// RAS_IDLE    | normal operation; call/ret/ckpt accepted unless flushing
// RAS_RECOVER | one cycle after a flush; call/ret/ckpt ignored, o_busy=1
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int DATAWIDTH = RAS_DATAWIDTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_call,
    input  logic [DATAWIDTH-1:0]     i_call_pc,
    input  logic                     i_ret,
    output logic [DATAWIDTH-1:0]     o_pred_pc,
    output logic                     o_pred_valid,
    input  logic                     i_ckpt_en,
    input  logic [RAS_CKPT_LOG2-1:0] i_ckpt_tag,
    input  logic                     i_flush,
    input  logic [RAS_CKPT_LOG2-1:0] i_flush_tag,
    input  logic                     i_ckpt_free,
    input  logic [RAS_CKPT_LOG2-1:0] i_free_tag,
    output logic                     o_busy,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int DEPTH_LOG2 = RAS_DEPTH_LOG2;

    ras_state_e              state_q, state_d;
    logic [DEPTH_LOG2-1:0]   tos_q, tos_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic [RAS_NUM_CKPT-1:0] valid_q, valid_d;
    ras_ckpt_t               slot_q [RAS_NUM_CKPT];

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  nonempty;
    logic [DEPTH_LOG2-1:0] tos_m1;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic                  ckpt_we;
    ras_ckpt_t             ckpt_d;
    ras_ckpt_t             restore;

    ras_stack_mem #(
        .DATAWIDTH  (DATAWIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (i_call_pc),
        .raddr_i (tos_m1),
        .rdata_o (o_pred_pc)
    );

    always_comb begin
        tos_m1       = tos_q - 1'b1;
        accept       = (state_q == RAS_IDLE) && !i_flush;
        push         = accept && i_call;
        pop          = accept && i_ret;
        nonempty     = (count_q != '0);
        tos_d        = tos_q;
        count_d      = count_q;
        mem_we       = 1'b0;
        mem_waddr    = tos_q;
        o_pred_valid = 1'b0;
        state_d      = RAS_IDLE;
        valid_d      = valid_q;
        ckpt_we      = 1'b0;
        restore      = valid_q[i_flush_tag] ? slot_q[i_flush_tag] : '0;

        if (push && pop && nonempty) begin
            // Call-through-return: replace the top entry in place.
            mem_we       = 1'b1;
            mem_waddr    = tos_m1;
            o_pred_valid = 1'b1;
        end else if (push) begin
            // Wrapping overwrites the oldest entry; count saturates.
            mem_we  = 1'b1;
            tos_d   = tos_q + 1'b1;
            count_d = (count_q == RAS_COUNT_FULL) ? count_q : count_q + 1'b1;
        end else if (pop && nonempty) begin
            o_pred_valid = 1'b1;
            tos_d        = tos_m1;
            count_d      = count_q - 1'b1;
        end

        // Snapshot taken from the post-update pointer and count.
        ckpt_d = '{tos: tos_d, count: count_d};

        if (i_flush) begin
            tos_d                = restore.tos;
            count_d              = restore.count;
            state_d              = RAS_RECOVER;
            valid_d              = '0;
            valid_d[i_flush_tag] = valid_q[i_flush_tag];
        end else begin
            if (i_ckpt_free) begin
                valid_d[i_free_tag] = 1'b0;
            end
            if (accept && i_ckpt_en) begin
                valid_d[i_ckpt_tag] = 1'b1;
                ckpt_we             = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RAS_IDLE;
            tos_q   <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < RAS_NUM_CKPT; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            tos_q   <= tos_d;
            count_q <= count_d;
            valid_q <= valid_d;
            if (ckpt_we) begin
                slot_q[i_ckpt_tag] <= ckpt_d;
            end
        end
    end

    assign o_busy  = (state_q == RAS_RECOVER);
    assign o_full  = (count_q == RAS_COUNT_FULL);
    assign o_empty = (count_q == '0);

endmodule
